// File: rtl/ocx_tlx_pkg.sv
// Shared TLX definitions: gate FSM encoding and command-entry field positions.
package ocx_tlx_pkg;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_ERR  = 2'd2
    } gate_state_e;

    localparam int         DCP_CNT_MSB = 171;
    localparam int         DCP_CNT_LSB = 168;
    localparam logic [3:0] DCP_MAX     = 4'd4;

    // A command may be followed by at most DCP_MAX data flits.
    function automatic logic dcp_cnt_bad(input logic [3:0] cnt);
        return (cnt > DCP_MAX);
    endfunction

endpackage

// File: rtl/ocx_tlx_cmd_credit_gate_if.sv
// Command FIFO read side plus the registered valid/ready stage toward the flit packer.
interface ocx_tlx_cmd_credit_gate_if #(
    parameter int DATA_WIDTH = 172
);
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_avail;
    logic                  fifo_rd_done;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    modport master (
        input  fifo_data, fifo_avail, out_ready,
        output fifo_rd_done, out_valid, out_data
    );

    modport slave (
        output fifo_data, fifo_avail, out_ready,
        input  fifo_rd_done, out_valid, out_data
    );
endinterface

// File: rtl/ocx_tlx_credit_counter.sv
// One TL credit pool: load, return/consume in the same cycle, saturate on overflow, hold on underflow.
module ocx_tlx_credit_counter #(
    parameter int CRED_WIDTH = 8,
    parameter int RET_WIDTH  = 6,
    parameter int CONS_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [CRED_WIDTH-1:0] load_val,
    input  logic                  en,
    input  logic [RET_WIDTH-1:0]  ret,
    input  logic [CONS_WIDTH-1:0] consume,
    output logic [CRED_WIDTH-1:0] count,
    output logic                  err
);
    localparam int SW = CRED_WIDTH + 2;

    logic [SW-1:0] nxt_s;
    logic          ovf_s;
    logic          unf_s;

    // Two guard bits: top bit marks a negative result, next bit marks a value above the maximum.
    always_comb begin
        nxt_s = SW'(count) + SW'(ret) - SW'(consume);
        unf_s = nxt_s[SW-1];
        ovf_s = !nxt_s[SW-1] && nxt_s[SW-2];
        err   = en && (ovf_s || unf_s);
    end

    // Credit register update.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= {CRED_WIDTH{1'b0}};
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            if (ovf_s) begin
                count <= {CRED_WIDTH{1'b1}};
            end else if (unf_s) begin
                count <= count;
            end else begin
                count <= nxt_s[CRED_WIDTH-1:0];
            end
        end else begin
            count <= count;
        end
    end
endmodule

// File: rtl/ocx_tlx_cmd_credit_gate.sv
// Pops TLX commands only when VC and DCP credits cover them; one-deep registered output stage.
// Stall statistics counter is built only when OCX_TLX_CMD_GATE_STATS_EN is defined.
module ocx_tlx_cmd_credit_gate
    import ocx_tlx_pkg::*;
#(
    parameter int DATA_WIDTH = 172,
    parameter int CRED_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    ocx_tlx_cmd_credit_gate_if.master bus,
    input  logic                      cred_init_valid,
    input  logic [CRED_WIDTH-1:0]     cred_init_vc,
    input  logic [CRED_WIDTH-1:0]     cred_init_dcp,
    input  logic [3:0]                ret_vc,
    input  logic [5:0]                ret_dcp,
    output logic [CRED_WIDTH-1:0]     vc_credits,
    output logic [CRED_WIDTH-1:0]     dcp_credits,
    output logic                      cred_error,
    output logic [15:0]               stall_count
);
    gate_state_e           state_r;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic                  cred_error_r;

    logic       run_s;
    logic       load_s;
    logic [3:0] dcp_cnt_s;
    logic       cnt_bad_s;
    logic       stage_free_s;
    logic       cred_ok_s;
    logic       pop_s;
    logic       bad_cnt_err_s;
    logic [3:0] dcp_consume_s;
    logic       vc_err_s;
    logic       dcp_err_s;

    // Pop decision uses only the credits held at the start of the cycle.
    always_comb begin
        run_s         = (state_r == S_RUN);
        load_s        = (state_r == S_INIT) && cred_init_valid;
        dcp_cnt_s     = bus.fifo_data[DCP_CNT_MSB:DCP_CNT_LSB];
        cnt_bad_s     = dcp_cnt_bad(dcp_cnt_s);
        stage_free_s  = !out_valid_r || bus.out_ready;
        cred_ok_s     = (vc_credits != {CRED_WIDTH{1'b0}}) &&
                        (dcp_credits >= CRED_WIDTH'(dcp_cnt_s));
        pop_s         = reset_n && run_s && bus.fifo_avail && !cnt_bad_s &&
                        cred_ok_s && stage_free_s;
        bad_cnt_err_s = run_s && bus.fifo_avail && cnt_bad_s;
        dcp_consume_s = pop_s ? dcp_cnt_s : 4'd0;
    end

    ocx_tlx_credit_counter #(
        .CRED_WIDTH (CRED_WIDTH),
        .RET_WIDTH  (4),
        .CONS_WIDTH (1)
    ) u_vc_cred (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (load_s),
        .load_val (cred_init_vc),
        .en       (run_s),
        .ret      (ret_vc),
        .consume  (pop_s),
        .count    (vc_credits),
        .err      (vc_err_s)
    );

    ocx_tlx_credit_counter #(
        .CRED_WIDTH (CRED_WIDTH),
        .RET_WIDTH  (6),
        .CONS_WIDTH (4)
    ) u_dcp_cred (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (load_s),
        .load_val (cred_init_dcp),
        .en       (run_s),
        .ret      (ret_dcp),
        .consume  (dcp_consume_s),
        .count    (dcp_credits),
        .err      (dcp_err_s)
    );

    // Gate FSM plus output stage; the stage keeps draining in every state.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r      <= S_INIT;
            cred_error_r <= 1'b0;
            out_valid_r  <= 1'b0;
            out_data_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                S_INIT: begin
                    if (cred_init_valid) state_r <= S_RUN;
                    else                 state_r <= S_INIT;
                end
                S_RUN: begin
                    if (vc_err_s || dcp_err_s || bad_cnt_err_s) begin
                        state_r      <= S_ERR;
                        cred_error_r <= 1'b1;
                    end else begin
                        state_r <= S_RUN;
                    end
                end
                S_ERR: begin
                    state_r      <= S_ERR;
                    cred_error_r <= 1'b1;
                end
                default: begin
                    state_r      <= S_ERR;
                    cred_error_r <= 1'b1;
                end
            endcase

            if (pop_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= bus.fifo_data;
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign bus.fifo_rd_done = pop_s;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_data     = out_data_r;
    assign cred_error       = cred_error_r;

`ifdef OCX_TLX_CMD_GATE_STATS_EN
    logic        stall_s;
    logic [15:0] stall_count_r;

    assign stall_s = run_s && bus.fifo_avail && stage_free_s && !cred_ok_s && !cnt_bad_s;

    // Saturating count of cycles lost to missing credits.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_count_r <= 16'h0000;
        end else if (stall_s && (stall_count_r != 16'hFFFF)) begin
            stall_count_r <= stall_count_r + 16'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign stall_count = stall_count_r;
`else
    assign stall_count = 16'h0000;
`endif
endmodule

// File: tb/tb_ocx_tlx_cmd_credit_gate.sv
// Directed and randomized bench for ocx_tlx_cmd_credit_gate against a queue/integer credit model.
module tb_ocx_tlx_cmd_credit_gate;
    localparam int M_INIT = 0;
    localparam int M_RUN  = 1;
    localparam int M_ERR  = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cred_init_valid;
    logic [7:0]  cred_init_vc;
    logic [7:0]  cred_init_dcp;
    logic [3:0]  ret_vc;
    logic [5:0]  ret_dcp;
    logic [7:0]  vc_credits;
    logic [7:0]  dcp_credits;
    logic        cred_error;
    logic [15:0] stall_count;

    ocx_tlx_cmd_credit_gate_if #(.DATA_WIDTH(172)) bif ();

    ocx_tlx_cmd_credit_gate #(.DATA_WIDTH(172), .CRED_WIDTH(8)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .bus             (bif),
        .cred_init_valid (cred_init_valid),
        .cred_init_vc    (cred_init_vc),
        .cred_init_dcp   (cred_init_dcp),
        .ret_vc          (ret_vc),
        .ret_dcp         (ret_dcp),
        .vc_credits      (vc_credits),
        .dcp_credits     (dcp_credits),
        .cred_error      (cred_error),
        .stall_count     (stall_count)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [171:0] q[$];
    int           m_mode  = M_INIT;
    int           m_vc    = 0;
    int           m_dcp   = 0;
    int           m_err   = 0;
    int           m_stall = 0;
    bit           m_ov    = 1'b0;
    logic [171:0] m_od    = 172'd0;

    task automatic check(input string tag, input logic [171:0] obs, input logic [171:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [171:0] mk(input logic [3:0] cnt);
        logic [171:0] e;
        e = 172'd0;
        for (int i = 0; i < 6; i++) e = {e[139:0], 32'($urandom())};
        e[171:168] = cnt;
        return e;
    endfunction

    // One clock cycle: predict, check at mid-cycle, then advance the model past the edge.
    task automatic tick();
        bit         avail, free, ok, exp_pop, bad;
        logic [3:0] cnt;
        int         nv, nd;
        avail          = (q.size() != 0);
        bif.fifo_avail = avail;
        bif.fifo_data  = avail ? q[0] : 172'd0;
        cnt            = bif.fifo_data[171:168];
        free           = !m_ov || bif.out_ready;
        ok             = (m_vc >= 1) && (m_dcp >= int'(cnt));
        exp_pop        = reset_n && (m_mode == M_RUN) && avail && (cnt <= 4'd4) && ok && free;
        #4;
        check("rd_done",   172'(bif.fifo_rd_done), 172'(exp_pop));
        check("out_valid", 172'(bif.out_valid),    172'(m_ov));
        check("out_data",  bif.out_data,           m_od);
        check("vc",        172'(vc_credits),       172'(m_vc));
        check("dcp",       172'(dcp_credits),      172'(m_dcp));
        check("cred_err",  172'(cred_error),       172'(m_err));
        check("stall",     172'(stall_count),      172'(m_stall));
        @(posedge clock);
        #1;
        if (!reset_n) begin
            m_mode = M_INIT; m_vc = 0; m_dcp = 0; m_err = 0; m_stall = 0;
            m_ov = 1'b0; m_od = 172'd0;
        end else begin
            if (exp_pop) begin
                m_od = q[0];
                void'(q.pop_front());
                m_ov = 1'b1;
            end else if (bif.out_ready) begin
                m_ov = 1'b0;
            end
            if (m_mode == M_INIT) begin
                if (cred_init_valid) begin
                    m_vc = int'(cred_init_vc); m_dcp = int'(cred_init_dcp); m_mode = M_RUN;
                end
            end else if (m_mode == M_RUN) begin
                bad = 1'b0;
                nv  = m_vc + int'(ret_vc) - (exp_pop ? 1 : 0);
                nd  = m_dcp + int'(ret_dcp) - (exp_pop ? int'(cnt) : 0);
                if (nv > 255) begin nv = 255; bad = 1'b1; end
                else if (nv < 0) begin nv = m_vc; bad = 1'b1; end
                if (nd > 255) begin nd = 255; bad = 1'b1; end
                else if (nd < 0) begin nd = m_dcp; bad = 1'b1; end
                if (avail && cnt > 4'd4) bad = 1'b1;
`ifdef OCX_TLX_CMD_GATE_STATS_EN
                if (avail && free && !ok && cnt <= 4'd4 && m_stall < 65535) m_stall++;
`endif
                m_vc = nv; m_dcp = nd;
                if (bad) begin m_mode = M_ERR; m_err = 1; end
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; cred_init_valid = 1'b0; ret_vc = 4'd0; ret_dcp = 6'd0;
        bif.out_ready = 1'b0;
        q.delete();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic do_init(input logic [7:0] vc, input logic [7:0] dcp);
        cred_init_valid = 1'b1; cred_init_vc = vc; cred_init_dcp = dcp;
        tick();
        cred_init_valid = 1'b0;
    endtask

    logic [171:0] held;

    initial begin
        reset_n = 1'b0; cred_init_valid = 1'b0; cred_init_vc = 8'd0; cred_init_dcp = 8'd0;
        ret_vc = 4'd0; ret_dcp = 6'd0;
        bif.out_ready = 1'b0; bif.fifo_avail = 1'b0; bif.fifo_data = 172'd0;
        @(posedge clock);
        #1;

        // 1: no init, FIFO non-empty for 20 cycles
        do_reset();
        for (int i = 0; i < 3; i++) q.push_back(mk(4'(i)));
        bif.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("t1_no_valid", 172'(bif.out_valid), 172'd0);
        check("t1_vc_zero",  172'(vc_credits),    172'd0);

        // 2: VC-limited pops, then a single VC return releases the third
        do_reset();
        do_init(8'd2, 8'd8);
        for (int i = 0; i < 3; i++) q.push_back(mk(4'd0));
        bif.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("t2_vc_empty", 172'(vc_credits), 172'd0);
        ret_vc = 4'd1;
        tick();
        ret_vc = 4'd0;
        tick();
        tick();
        check("t2_third_out", 172'(bif.out_valid), 172'd0);

        // 3: DCP-limited entry; init pulse in run is ignored
        do_reset();
        do_init(8'd4, 8'd3);
        cred_init_valid = 1'b1; cred_init_vc = 8'd99; cred_init_dcp = 8'd99;
        tick();
        cred_init_valid = 1'b0;
        q.push_back(mk(4'd4));
        bif.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        ret_dcp = 6'd1;
        tick();
        ret_dcp = 6'd0;
        tick();
        check("t3_dcp_zero", 172'(dcp_credits), 172'd0);
        tick();

        // 4: backpressure holds out_data; second pop when ready rises
        do_reset();
        do_init(8'd10, 8'd10);
        q.push_back(mk(4'd1));
        q.push_back(mk(4'd1));
        held = q[0];
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_hold", bif.out_data, held);
        end
        bif.out_ready = 1'b1;
        tick();
        tick();

        // 5: VC overflow saturates and locks the gate
        do_reset();
        do_init(8'd250, 8'd10);
        ret_vc = 4'd8;
        tick();
        ret_vc = 4'd0;
        check("t5_vc_sat", 172'(vc_credits), 172'd255);
        check("t5_err",    172'(cred_error), 172'd1);
        q.push_back(mk(4'd0));
        bif.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        // 6: stall statistics with no VC credits
        do_reset();
        do_init(8'd0, 8'd10);
        q.push_back(mk(4'd0));
        bif.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) tick();
`ifdef OCX_TLX_CMD_GATE_STATS_EN
        check("t6_stall", 172'(stall_count), 172'd7);
`else
        check("t6_stall", 172'(stall_count), 172'd0);
`endif

        // 7: illegal dcp_cnt is an error, not a pop
        do_reset();
        do_init(8'd5, 8'd10);
        q.push_back(mk(4'd5));
        tick();
        check("t7_err", 172'(cred_error), 172'd1);
        tick();

        // 8: randomized traffic
        do_reset();
        do_init(8'($urandom_range(0, 40)), 8'($urandom_range(0, 40)));
        for (int i = 0; i < 400; i++) begin
            if (q.size() < 4 && $urandom_range(0, 2) != 0) q.push_back(mk(4'($urandom_range(0, 4))));
            bif.out_ready = ($urandom_range(0, 9) < 7);
            ret_vc  = ($urandom_range(0, 2) == 0) ? 4'd1 : 4'd0;
            ret_dcp = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 3)) : 6'd0;
            tick();
        end
        ret_vc = 4'd0; ret_dcp = 6'd0;
        do_reset();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
